// File: rtl/output_fifo_pkg.sv
// Shared constants for the output FIFO that sits on the MAC array south edge.
// Defaults: COL columns, PSUM_BW-bit partial sums, DEPTH entries per column,
// PTR_W = log2(DEPTH) pointer width.
package output_fifo_pkg;
   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int DEPTH   = 64;
   localparam int PTR_W   = $clog2(DEPTH);
endpackage

// File: rtl/output_fifo_if.sv
// Handshake bundle for output_fifo: row data in/out, per-column write strobes,
// row pop request, and status flags.
//   master : producer/consumer side (drives in, wr, rd; observes the rest)
//   slave  : FIFO side
interface output_fifo_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16
);
   logic [psum_bw*col-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [psum_bw*col-1:0] out;
   logic                   out_valid;
   logic                   o_ready;
   logic                   o_full;
   logic                   o_avail;

   modport master (output in, wr, rd, input out, out_valid, o_ready, o_full, o_avail);
   modport slave  (input in, wr, rd, output out, out_valid, o_ready, o_full, o_avail);
endinterface

// File: rtl/output_fifo_col.sv
// One column FIFO: storage, write pointer and occupancy count.
// The read pointer is owned by the parent and shared by all columns.
//   clk, reset : clock, async active-high reset
//   din, wr    : write data and strobe
//   pop        : accepted row pop (already qualified by the parent)
//   rd_ptr     : shared read pointer; head is mem[rd_ptr]
//   full/empty : occupancy flags
module output_fifo_col #(
   parameter int psum_bw = 16,
   parameter int depth   = 64,
   localparam int ptr_w  = $clog2(depth)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [psum_bw-1:0] din,
   input  logic               wr,
   input  logic               pop,
   input  logic [ptr_w-1:0]   rd_ptr,
   output logic [psum_bw-1:0] head,
   output logic               full,
   output logic               empty
);
   localparam logic [ptr_w:0] FULL_CNT = (ptr_w+1)'(depth);

   logic [psum_bw-1:0] mem [depth];
   logic [ptr_w-1:0]   wr_ptr;
   logic [ptr_w:0]     count;
   logic               wr_acc;

   // A write to a full column still lands if a pop frees a slot this cycle.
   assign wr_acc = wr && (!full || pop);
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + ptr_w'(1);
         count <= count + (ptr_w+1)'(wr_acc) - (ptr_w+1)'(pop);
      end
   end
endmodule

// File: rtl/output_fifo.sv
// Row-oriented output FIFO: col independent column FIFOs written by the MAC
// array valid vector, popped a full row at a time through a shared read pointer.
//   clk, reset : clock, async active-high reset
//   in, wr     : packed column data, per-column write strobes
//   rd         : row pop request (honoured only while o_avail)
//   out        : registered popped row, out_valid pulses one cycle per pop
//   o_ready/o_full/o_avail : combinational status from column counts
// Optional macro OUTPUT_FIFO_RELU_EN: clamp negative popped values to zero.
module output_fifo
   import output_fifo_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   out_valid,
   output logic                   o_ready,
   output logic                   o_full,
   output logic                   o_avail
);
   localparam int ptr_w = $clog2(depth);

   logic [ptr_w-1:0]       rd_ptr;
   logic [col-1:0]         full_v;
   logic [col-1:0]         empty_v;
   logic [psum_bw*col-1:0] head_row;
   logic [psum_bw*col-1:0] load_row;
   logic                   pop;

   assign o_avail = ~|empty_v;
   assign o_full  = |full_v;
   assign o_ready = ~o_full;
   assign pop     = rd && o_avail;

   for (genvar c = 0; c < col; c++) begin : g_col
      output_fifo_col #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_col (
         .clk    (clk),
         .reset  (reset),
         .din    (in[psum_bw*c +: psum_bw]),
         .wr     (wr[c]),
         .pop    (pop),
         .rd_ptr (rd_ptr),
         .head   (head_row[psum_bw*c +: psum_bw]),
         .full   (full_v[c]),
         .empty  (empty_v[c])
      );

`ifdef OUTPUT_FIFO_RELU_EN
      assign load_row[psum_bw*c +: psum_bw] =
         head_row[psum_bw*(c+1)-1] ? '0 : head_row[psum_bw*c +: psum_bw];
`else
      assign load_row[psum_bw*c +: psum_bw] = head_row[psum_bw*c +: psum_bw];
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= pop;
         if (pop) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
            out    <= load_row;
         end
      end
   end
endmodule

// File: tb/tb_output_fifo.sv
module tb_output_fifo;
   localparam int C = 8;
   localparam int W = 16;
   localparam int D = 64;

   logic clk;
   logic reset;
   int   checks;
   int   passed;

   output_fifo_if #(.col(C), .psum_bw(W)) bus ();

   output_fifo #(.col(C), .psum_bw(W), .depth(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (bus.in),
      .wr        (bus.wr),
      .rd        (bus.rd),
      .out       (bus.out),
      .out_valid (bus.out_valid),
      .o_ready   (bus.o_ready),
      .o_full    (bus.o_full),
      .o_avail   (bus.o_avail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W*C-1:0] row_data(input int r);
      logic [W*C-1:0] v;
      v = '0;
      for (int c = 0; c < C; c++)
         v[W*c +: W] = {8'(r), 8'(c)};
      return v;
   endfunction

   function automatic logic [W*C-1:0] fill(input logic [W-1:0] x);
      logic [W*C-1:0] v;
      for (int c = 0; c < C; c++)
         v[W*c +: W] = x;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      bus.wr = '0; bus.rd = 1'b0; bus.in = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic write_rows(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.wr = '1; bus.in = row_data(i);
      end
      @(negedge clk);
      bus.wr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.wr = '0; bus.rd = 1'b0; bus.in = '0;
      #12;
      checks++;
      if ({bus.o_ready, bus.o_full, bus.o_avail, bus.out_valid} !== 4'b1000)
         $display("FAIL reset_flags: got %b want 1000", {bus.o_ready, bus.o_full, bus.o_avail, bus.out_valid});
      else passed++;
      checks++;
      if (bus.out !== '0) $display("FAIL reset_out: got %h want 0", bus.out);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_skewed_fill();
      logic [W*C-1:0] exp;
      for (int c = 0; c < C; c++) exp[W*c +: W] = 16'h0100 + 16'(c);
      for (int k = 0; k < C; k++) begin
         @(negedge clk);
         bus.wr = 8'((16'(1) << (k+1)) - 1);
         bus.in = exp;
         @(posedge clk);
         #1;
         bus.wr = '0;
         checks++;
         if (bus.o_avail !== (k == C-1))
            $display("FAIL skew_avail_%0d: got %b want %b", k, bus.o_avail, (k == C-1));
         else passed++;
      end
      @(negedge clk);
      bus.rd = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL skew_valid_early: got %b want 0", bus.out_valid);
      else passed++;
      @(negedge clk);
      bus.rd = 1'b0;
      checks++;
      if (bus.out !== exp || bus.out_valid !== 1'b1)
         $display("FAIL skew_pop: got %h/%b want %h/1", bus.out, bus.out_valid, exp);
      else passed++;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out !== exp)
         $display("FAIL skew_hold: got %h/%b want %h/0", bus.out, bus.out_valid, exp);
      else passed++;
   endtask

   task automatic test_full();
      int bad;
      write_rows(D);
      checks++;
      if ({bus.o_full, bus.o_ready, bus.o_avail} !== 3'b101)
         $display("FAIL full_flags: got %b want 101", {bus.o_full, bus.o_ready, bus.o_avail});
      else passed++;
      // 65th write must be dropped
      bus.wr = '1; bus.in = fill(16'hDEAD);
      @(negedge clk);
      bus.wr = '0;
      bus.rd = 1'b1;
      bad = 0;
      for (int i = 0; i < D; i++) begin
         @(negedge clk);
         if (i == D-1) bus.rd = 1'b0;
         checks++;
         if (bus.out !== row_data(i) || bus.out_valid !== 1'b1) begin
            $display("FAIL full_pop_%0d: got %h/%b want %h/1", i, bus.out, bus.out_valid, row_data(i));
            bad++;
         end else passed++;
      end
      checks++;
      if (bus.o_avail !== 1'b0 || bus.o_ready !== 1'b1)
         $display("FAIL full_drained: avail %b ready %b want 0 1", bus.o_avail, bus.o_ready);
      else passed++;
   endtask

   task automatic test_wr_pop_full();
      write_rows(D);
      bus.wr = '1; bus.in = fill(16'hBEEF); bus.rd = 1'b1;
      @(negedge clk);
      bus.wr = '0;
      checks++;
      if (bus.out !== row_data(0) || bus.o_full !== 1'b1)
         $display("FAIL wrpop_first: got %h full %b want %h full 1", bus.out, bus.o_full, row_data(0));
      else passed++;
      for (int i = 1; i < D; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out !== row_data(i))
            $display("FAIL wrpop_row_%0d: got %h want %h", i, bus.out, row_data(i));
         else passed++;
      end
      @(negedge clk);
      bus.rd = 1'b0;
      checks++;
      if (bus.out !== fill(16'hBEEF) || bus.o_avail !== 1'b0)
         $display("FAIL wrpop_beef: got %h avail %b want %h avail 0", bus.out, bus.o_avail, fill(16'hBEEF));
      else passed++;
   endtask

   task automatic test_rd_empty();
      @(negedge clk);
      bus.rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out !== fill(16'hBEEF) || bus.out_valid !== 1'b0)
            $display("FAIL rd_empty_%0d: got %h/%b want %h/0", i, bus.out, bus.out_valid, fill(16'hBEEF));
         else passed++;
      end
      bus.rd = 1'b0;
      bus.wr = '1; bus.in = fill(16'h1234);
      @(negedge clk);
      bus.wr = '0; bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      checks++;
      if (bus.out !== fill(16'h1234) || bus.o_avail !== 1'b0)
         $display("FAIL rd_empty_after: got %h avail %b want %h avail 0", bus.out, bus.o_avail, fill(16'h1234));
      else passed++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      write_rows(10);
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      checks++;
      if (bus.out !== row_data(0)) $display("FAIL mid_prepop: got %h want %h", bus.out, row_data(0));
      else passed++;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out !== '0 || {bus.o_avail, bus.o_ready, bus.o_full, bus.out_valid} !== 4'b0100)
         $display("FAIL mid_reset: out %h flags %b want 0 0100", bus.out,
                  {bus.o_avail, bus.o_ready, bus.o_full, bus.out_valid});
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      bus.wr = '1; bus.in = fill(16'h5A5A);
      @(negedge clk);
      bus.in = fill(16'h0F0F);
      @(negedge clk);
      bus.wr = '0; bus.rd = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out !== fill(16'h5A5A)) $display("FAIL mid_post0: got %h want %h", bus.out, fill(16'h5A5A));
      else passed++;
      @(negedge clk);
      bus.rd = 1'b0;
      checks++;
      if (bus.out !== fill(16'h0F0F) || bus.o_avail !== 1'b0)
         $display("FAIL mid_post1: got %h avail %b want %h avail 0", bus.out, bus.o_avail, fill(16'h0F0F));
      else passed++;
   endtask

   task automatic test_relu();
      logic [W*C-1:0] v;
      logic [W*C-1:0] exp;
      v = '0;
      v[W*0 +: W] = 16'hFFF0;
      v[W*1 +: W] = 16'h0010;
      exp = v;
`ifdef OUTPUT_FIFO_RELU_EN
      exp[W*0 +: W] = 16'h0000;
`endif
      @(negedge clk);
      bus.wr = '1; bus.in = v;
      @(negedge clk);
      bus.wr = '0; bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      checks++;
      if (bus.out !== exp) $display("FAIL relu: got %h want %h", bus.out, exp);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_skewed_fill();
      do_reset();
      test_full();
      do_reset();
      test_wr_pop_full();
      test_rd_empty();
      test_reset_mid();
      test_relu();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/output_fifo.md
OUTPUT_FIFO -- requirements
Module: output_fifo

Interface
REQ-001 SHALL have parameter col, default 8, number of array columns and column FIFOs.
REQ-002 SHALL have parameter psum_bw, default 16, partial-sum width per column.
REQ-003 SHALL have parameter depth, default 64, entries per column FIFO (power of two, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in  input  psum_bw*col  partial sums from the MAC array south edge; column c at bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-007 SHALL have port wr  input  col  per-column write strobe, driven by the MAC array valid vector.
REQ-008 SHALL have port rd  input  1  pop request for one full row (all columns).
REQ-009 SHALL have port out  output  psum_bw*col  registered popped row, same column packing as in.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse marking out as newly updated.
REQ-011 SHALL have port o_ready  output  1  high when every column FIFO is not full.
REQ-012 SHALL have port o_full  output  1  high when any column FIFO is full.
REQ-013 SHALL have port o_avail  output  1  high when every column FIFO is non-empty.

Function
REQ-014 SHALL keep an independent write pointer and occupancy count (0..depth) per column; single read pointer shared by all columns.
REQ-015 SHALL, when wr[c]=1 and column c not full, store in column c slice at its write pointer, advance it modulo depth.
REQ-016 SHALL drop a write to a full column unless a pop is accepted the same cycle, in which case the write is accepted.
REQ-017 SHALL accept a pop only when rd=1 and o_avail=1; rd while o_avail=0 SHALL have no effect.
REQ-018 SHALL, on accepted pop at edge t, load out with all column heads and assert out_valid for exactly the cycle after t; out holds its value otherwise.
REQ-019 SHALL apply simultaneous write and pop to the same column in one cycle, leaving its count unchanged.
REQ-020 SHALL wrap all pointers from depth-1 to 0 with no gap or bubble.
REQ-021 SHALL derive o_ready, o_full, o_avail combinationally from current counts (no extra latency).
REQ-022 SHALL sustain one pop per cycle while o_avail remains high.

Reset
REQ-023 SHALL, on reset assertion, immediately clear all pointers, counts, out (zero) and out_valid (zero), discarding in-flight data, regardless of mid-operation state.
REQ-024 SHALL present o_ready=1, o_full=0, o_avail=0 while and after reset until writes occur.

Configuration
REQ-025 SHALL compile a ReLU stage on the read path when macro OUTPUT_FIFO_RELU_EN is defined: each popped column value that is negative (two's complement) is loaded into out as zero.
REQ-026 SHALL, without OUTPUT_FIFO_RELU_EN, load popped values into out unmodified.

Structure
REQ-027 SHALL place default COL, PSUM_BW, DEPTH and derived PTR_W=log2(DEPTH) constants in shared package output_fifo_pkg.
REQ-028 SHALL implement each column as an instance of sub-module output_fifo_col (storage, write pointer, count, full/empty), with shared read pointer and pop logic in output_fifo.

Verification
REQ-029 SHALL cover skewed fill: wr=8'h01,8'h03,...,8'hFF on successive cycles with column c writing 16'h0100+c -> o_avail rises only after column 7 write; rd gives out column c = 16'h0100+c, out_valid one cycle later.
REQ-030 SHALL cover full: 64 writes all columns with no rd -> o_full=1, o_ready=0; 65th write dropped; 64 pops return data in order, then o_avail=0.
REQ-031 SHALL cover simultaneous write+pop at full: write 16'hBEEF while popping -> count stays 64, BEEF later emerges as last entry.
REQ-032 SHALL cover rd while empty -> out unchanged, out_valid stays 0, pointers unchanged.
REQ-033 SHALL cover reset mid-stream: assert reset with 10 entries queued -> o_avail=0, out=0 immediately; post-reset writes read back correctly from pointer 0.
REQ-034 SHALL cover ReLU: with OUTPUT_FIFO_RELU_EN, pushing 16'hFFF0 and 16'h0010 -> out columns 0 and 16'h0010; without macro -> 16'hFFF0 and 16'h0010.
